// File: rtl/dfdd_window_pkg.sv
// Shared constants, FSM state type and helpers for the fp16 horizontal window generator.
package dfdd_window_pkg;

  localparam int unsigned FP16_EXP_WIDTH  = 5;
  localparam int unsigned FP16_FRAC_WIDTH = 10;
  localparam int unsigned FP16_WIDTH      = 1 + FP16_FRAC_WIDTH + FP16_EXP_WIDTH;

  localparam logic [FP16_WIDTH-1:0] FP_ZERO = '0;

  typedef enum logic [1:0] {
    StFill,
    StRun,
    StFlush
  } win_state_e;

  function automatic int unsigned half_of(input int unsigned window_width);
    return (window_width - 1) / 2;
  endfunction

endpackage

// File: rtl/window_shift_reg.sv
// Window shift register: shifts toward index 0, with a left-border clear and a zero-in mode.
module window_shift_reg #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             shift_i,
  input  logic             clear_i,
  input  logic             zero_in_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] sr_o [Depth]
);

  logic [Width-1:0] sr_q [Depth];
  logic [Width-1:0] sr_d [Depth];
  logic [Width-1:0] newest;

  assign newest = zero_in_i ? '0 : data_i;

  always_comb begin
    sr_d = sr_q;
    if (shift_i) begin
      // A clear wipes the older entries so the first pixel of a row sees zero padding.
      for (int unsigned k = 0; k + 1 < Depth; k++) begin
        sr_d[k] = clear_i ? '0 : sr_q[k+1];
      end
      sr_d[Depth-1] = newest;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < Depth; k++) begin
        sr_q[k] <= '0;
      end
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr_o = sr_q;

endmodule

// File: rtl/window_gen_h_fp16.sv
// Raster fp16 stream to centred 1xN horizontal windows with zero-padded row borders.
module window_gen_h_fp16
  import dfdd_window_pkg::*;
#(
  parameter int unsigned EXP_WIDTH     = FP16_EXP_WIDTH,
  parameter int unsigned FRAC_WIDTH    = FP16_FRAC_WIDTH,
  parameter int unsigned WINDOW_WIDTH  = 9,
  parameter int unsigned WINDOW_HEIGHT = 1,
  parameter int unsigned IMAGE_WIDTH   = 640,
  parameter int unsigned IMAGE_HEIGHT  = 480,
  localparam int unsigned FP_WIDTH_REG = 1 + FRAC_WIDTH + EXP_WIDTH,
  localparam int unsigned HALF         = half_of(WINDOW_WIDTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [FP_WIDTH_REG-1:0] data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [FP_WIDTH_REG-1:0] window_o [WINDOW_HEIGHT][WINDOW_WIDTH],
  output logic [15:0]             col_o,
  output logic [15:0]             row_o,
  output logic                    valid_o
);

  localparam logic [15:0] LastCol   = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] LastRow   = 16'(IMAGE_HEIGHT - 1);
  localparam logic [15:0] HalfW     = 16'(HALF);
  localparam logic [15:0] HalfM1    = 16'(HALF - 1);
  localparam logic [15:0] FlushBase = 16'(IMAGE_WIDTH - HALF);
  localparam bit          NoPad     = (HALF == 0);

  win_state_e  state_q;
  logic [15:0] in_col_q;
  logic [15:0] out_row_q;
  logic [15:0] flush_cnt_q;
  logic [15:0] col_q;
  logic [15:0] row_q;
  logic        valid_q;
  logic        hs;
  logic [15:0] next_row;

  logic [FP_WIDTH_REG-1:0] sr [WINDOW_WIDTH];

  assign ready_o  = (state_q != StFlush);
  assign hs       = valid_i & ready_o;
  assign next_row = (out_row_q == LastRow) ? 16'd0 : out_row_q + 16'd1;

  window_shift_reg #(
    .Width(FP_WIDTH_REG),
    .Depth(WINDOW_WIDTH)
  ) u_shift_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .shift_i  (hs | (state_q == StFlush)),
    .clear_i  (hs & (in_col_q == 16'd0)),
    .zero_in_i(state_q == StFlush),
    .data_i   (data_i),
    .sr_o     (sr)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StFill;
      in_col_q    <= '0;
      out_row_q   <= '0;
      flush_cnt_q <= '0;
      col_q       <= '0;
      row_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StFill, StRun: begin
          if (hs) begin
            // With no padding every accepted pixel is already a window centre.
            if (state_q == StRun || NoPad) begin
              valid_q <= 1'b1;
              col_q   <= in_col_q - HalfW;
              row_q   <= out_row_q;
            end
            if (in_col_q == LastCol) begin
              in_col_q <= '0;
              if (NoPad) begin
                out_row_q <= next_row;
              end else begin
                state_q     <= StFlush;
                flush_cnt_q <= '0;
              end
            end else begin
              in_col_q <= in_col_q + 16'd1;
              if (state_q == StFill && in_col_q == HalfM1) begin
                state_q <= StRun;
              end
            end
          end
        end
        StFlush: begin
          valid_q <= 1'b1;
          col_q   <= FlushBase + flush_cnt_q;
          row_q   <= out_row_q;
          if (flush_cnt_q == HalfM1) begin
            state_q     <= StFill;
            flush_cnt_q <= '0;
            out_row_q   <= next_row;
          end else begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  always_comb begin
    for (int unsigned h = 0; h < WINDOW_HEIGHT; h++) begin
      for (int unsigned k = 0; k < WINDOW_WIDTH; k++) begin
        window_o[h][k] = sr[k];
      end
    end
  end

  assign col_o   = col_q;
  assign row_o   = row_q;
  assign valid_o = valid_q;

endmodule
